// File: rtl/arbitro_rr_mux2a1dosbits_pkg.sv
// Shared definitions for the two-lane round-robin scheduler: grant-history
// states and default word/FIFO sizes.
package arbitro_rr_mux2a1dosbits_pkg;

    localparam int DEF_DATA_W = 2;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAST0 = 2'd1,
        ST_LAST1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arbitro_rr_mux2a1dosbits_fifo.sv
// Small synchronous FIFO with a combinational head word; a push into a full
// FIFO is taken only when a pop frees a slot at the same edge.
module fifo_dosbits #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push_ok, w_pop_ok;

    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/arbitro_rr_mux2a1dosbits.sv
// Round-robin scheduler for the 2:1 two-bit mux lane pair: two input FIFOs,
// one registered output word per cycle, sticky overflow flag.
module arbitro_rr_mux2a1dosbits
    import arbitro_rr_mux2a1dosbits_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in1,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              pause,
    output logic              fifo_full0,
    output logic              fifo_full1,
    output logic              fifo_empty0,
    output logic              fifo_empty1,
    output logic              selector_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              overflow_err
);
    arb_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] w_dout0, w_dout1;
    logic              w_pop0, w_pop1, w_any_pop, w_grant;
    logic              r_valid, r_sel, r_ovf;
    logic [DATA_W-1:0] r_data;

    fifo_dosbits #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .reset_L(reset_L), .push(valid_in0), .pop(w_pop0),
        .din(data_in0), .dout(w_dout0), .full(fifo_full0), .empty(fifo_empty0)
    );

    fifo_dosbits #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset_L(reset_L), .push(valid_in1), .pop(w_pop1),
        .din(data_in1), .dout(w_dout1), .full(fifo_full1), .empty(fifo_empty1)
    );

    // IDLE behaves exactly like LAST1, so lane 0 wins the first contested grant.
    always_comb begin
        w_any_pop   = !pause && !(fifo_empty0 && fifo_empty1);
        w_grant     = 1'b0;
        w_state_nxt = r_state;
        if (!fifo_empty0 && !fifo_empty1) w_grant = (r_state == ST_LAST0);
        else if (fifo_empty0)             w_grant = 1'b1;
        if (w_any_pop) w_state_nxt = w_grant ? ST_LAST1 : ST_LAST0;
        w_pop0 = w_any_pop && !w_grant;
        w_pop1 = w_any_pop &&  w_grant;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_LAST1;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_any_pop;
            if (w_any_pop) begin
                r_data <= w_grant ? w_dout1 : w_dout0;
                r_sel  <= w_grant;
            end else begin
                r_data <= '0;
            end
            if ((valid_in0 && fifo_full0 && !w_pop0) ||
                (valid_in1 && fifo_full1 && !w_pop1))
                r_ovf <= 1'b1;
        end
    end

    assign valid_out    = r_valid;
    assign data_out     = r_data;
    assign selector_out = r_sel;
    assign overflow_err = r_ovf;

endmodule
